// File: rtl/adc_responder.sv
// SPI responder emulating a two-channel 10-bit SAR ADC (MCP3002-style).
// SPI pins are oversampled on i_clk; SCLK is only ever treated as data.
module adc_responder #(
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              p_clk,
    input  logic              p_cs,
    input  logic              p_in,
    output logic              p_out,
    output logic              o_out_en,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_sample,
    output logic              o_channel,
    output logic              o_frame_error
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CFG,
        ST_NULL,
        ST_MSB,
        ST_LSB,
        ST_DONE
    } state_t;

    // synchronizers and edge history
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sclk_q;
    logic                   r_cs_q;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_din_s;
    logic w_sync_valid;
    logic w_rise;
    logic w_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    // frame state
    state_t            r_state;
    logic [1:0]        r_cfg_cnt;
    logic              r_sgl;
    logic              r_msbf;
    logic [DATA_W-1:0] r_value;
    logic [IDX_W-1:0]  r_index;
    logic              r_msb_done;
    logic              r_out;
    logic              r_out_en;
    logic              r_sample;
    logic              r_channel;
    logic              r_frame_error;

    state_t            w_state_next;
    logic [1:0]        w_cfg_cnt_next;
    logic              w_sgl_next;
    logic              w_msbf_next;
    logic [DATA_W-1:0] w_value_next;
    logic [IDX_W-1:0]  w_index_next;
    logic              w_msb_done_next;
    logic              w_out_next;
    logic              w_out_en_next;
    logic              w_sample_next;
    logic              w_channel_next;
    logic              w_frame_error_next;

    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_conv;
    logic [IDX_W-1:0]  w_index_inc;

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
    assign w_din_s      = r_din_sync[SYNC_STAGES-1];
    assign w_sync_valid = r_fill[SYNC_STAGES-1];

    assign w_rise    = w_sclk_s & ~r_sclk_q;
    assign w_fall    = ~w_sclk_s & r_sclk_q;
    assign w_cs_rise = w_cs_s & ~r_cs_q;
    assign w_cs_fall = ~w_cs_s & r_cs_q;

    assign w_index_inc = r_index + IDX_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_fill      <= '0;
            r_sclk_q    <= 1'b0;
            r_cs_q      <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], p_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], p_cs};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], p_in};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_q    <= w_sclk_s;
            r_cs_q      <= w_cs_s;
            // a frame only starts after CS has genuinely been seen high,
            // so a transfer interrupted by reset is not picked up halfway
            if (w_sync_valid && w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // conversion value; ODD arrives as the current DIN on the capture edge
    always_comb begin
        if (w_din_s) begin
            w_diff = {1'b0, i_data1} - {1'b0, i_data0};
        end else begin
            w_diff = {1'b0, i_data0} - {1'b0, i_data1};
        end
        if (r_sgl) begin
            w_conv = w_din_s ? i_data1 : i_data0;
        end else if (w_diff[DATA_W]) begin
            w_conv = '0;
        end else begin
            w_conv = w_diff[DATA_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cfg_cnt     <= '0;
            r_sgl         <= 1'b0;
            r_msbf        <= 1'b0;
            r_value       <= '0;
            r_index       <= '0;
            r_msb_done    <= 1'b0;
            r_out         <= 1'b0;
            r_out_en      <= 1'b0;
            r_sample      <= 1'b0;
            r_channel     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cfg_cnt     <= w_cfg_cnt_next;
            r_sgl         <= w_sgl_next;
            r_msbf        <= w_msbf_next;
            r_value       <= w_value_next;
            r_index       <= w_index_next;
            r_msb_done    <= w_msb_done_next;
            r_out         <= w_out_next;
            r_out_en      <= w_out_en_next;
            r_sample      <= w_sample_next;
            r_channel     <= w_channel_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cfg_cnt_next     = r_cfg_cnt;
        w_sgl_next         = r_sgl;
        w_msbf_next        = r_msbf;
        w_value_next       = r_value;
        w_index_next       = r_index;
        w_msb_done_next    = r_msb_done;
        w_out_next         = r_out;
        w_out_en_next      = r_out_en;
        w_sample_next      = 1'b0;
        w_channel_next     = r_channel;
        w_frame_error_next = 1'b0;

        if (w_cs_rise) begin
            w_state_next       = ST_IDLE;
            w_out_en_next      = 1'b0;
            w_out_next         = 1'b0;
            w_frame_error_next = (r_state == ST_CFG) || (r_state == ST_NULL) ||
                                 (r_state == ST_MSB) || (r_state == ST_LSB);
        end else if (!w_cs_s) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall && r_armed) begin
                        w_state_next = ST_START;
                    end
                end
                ST_START: begin
                    if (w_rise && w_din_s) begin
                        w_state_next   = ST_CFG;
                        w_cfg_cnt_next = 2'd0;
                    end
                end
                ST_CFG: begin
                    if (w_rise) begin
                        case (r_cfg_cnt)
                            2'd0: begin
                                w_sgl_next     = w_din_s;
                                w_cfg_cnt_next = 2'd1;
                            end
                            2'd1: begin
                                w_value_next   = w_conv;
                                w_sample_next  = 1'b1;
                                w_channel_next = w_din_s;
                                w_cfg_cnt_next = 2'd2;
                            end
                            default: begin
                                w_msbf_next  = w_din_s;
                                w_state_next = ST_NULL;
                            end
                        endcase
                    end
                end
                ST_NULL: begin
                    if (w_fall) begin
                        w_out_next      = 1'b0;
                        w_out_en_next   = 1'b1;
                        w_index_next    = IDX_W'(DATA_W - 1);
                        w_msb_done_next = 1'b0;
                        w_state_next    = ST_MSB;
                    end
                end
                ST_MSB: begin
                    if (w_fall) begin
                        if (!r_msb_done) begin
                            w_out_next = r_value[r_index];
                            if (r_index == '0) begin
                                w_msb_done_next = 1'b1;
                            end else begin
                                w_index_next = r_index - IDX_W'(1);
                            end
                        end else if (r_msbf) begin
                            w_state_next  = ST_DONE;
                            w_out_next    = 1'b0;
                            w_out_en_next = 1'b0;
                        end else begin
                            // LSB-first repeat starts at bit 1; bit 0 was the last MSB-first bit
                            w_state_next = ST_LSB;
                            w_out_next   = r_value[1];
                            w_index_next = IDX_W'(1);
                        end
                    end
                end
                ST_LSB: begin
                    if (w_fall) begin
                        if (r_index == IDX_W'(DATA_W - 1)) begin
                            w_state_next  = ST_DONE;
                            w_out_next    = 1'b0;
                            w_out_en_next = 1'b0;
                        end else begin
                            w_index_next = w_index_inc;
                            w_out_next   = r_value[w_index_inc];
                        end
                    end
                end
                ST_DONE: begin
                    w_out_next    = 1'b0;
                    w_out_en_next = 1'b0;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign p_out         = r_out;
    assign o_out_en      = r_out_en;
    assign o_sample      = r_sample;
    assign o_channel     = r_channel;
    assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: acts as the SPI initiator and checks DOUT against
// an expected bit-stream built from each frame's configuration and data.
module tb_adc_responder;
    localparam int DATA_W      = 10;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              p_clk;
    logic              p_cs;
    logic              p_in;
    logic              p_out;
    logic              o_out_en;
    logic [DATA_W-1:0] i_data0;
    logic [DATA_W-1:0] i_data1;
    logic              o_sample;
    logic              o_channel;
    logic              o_frame_error;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_samp;
    int                n_ferr;
    logic              last_chan;
    logic              chg_pending;
    logic [DATA_W-1:0] chg_val;

    adc_responder #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .p_clk         (p_clk),
        .p_cs          (p_cs),
        .p_in          (p_in),
        .p_out         (p_out),
        .o_out_en      (o_out_en),
        .i_data0       (i_data0),
        .i_data1       (i_data1),
        .o_sample      (o_sample),
        .o_channel     (o_channel),
        .o_frame_error (o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance n cycles, observing pulses at the falling edge of i_clk
    task automatic wait_clk(input int n);
        repeat (n) begin
            @(negedge i_clk);
            if (o_sample) begin
                n_samp++;
                last_chan = o_channel;
                if (chg_pending) begin
                    i_data0     = chg_val;
                    chg_pending = 1'b0;
                end
            end
            if (o_frame_error) n_ferr++;
        end
    endtask

    function automatic int conv_value(input bit sgl, input bit odd, input int d0, input int d1);
        int v;
        if (sgl) return odd ? d1 : d0;
        v = odd ? (d1 - d0) : (d0 - d1);
        return (v < 0) ? 0 : v;
    endfunction

    // bits[k] is DIN for SCLK k; rst_at>=0 pulses reset right after rise rst_at
    task automatic run_frame(input string name, input logic [63:0] bits, input int n_clk,
                             input bit cpol, input int d0, input int d1,
                             input bit chg, input int chg_to, input int rst_at);
        int s, j, exp_v, falls, need, exp_err, exp_samp, exp_end;
        bit sgl, odd, msbf;
        int value;
        int dout_q[$];

        s = -1;
        for (int k = 0; k < n_clk; k++) if (s < 0 && bits[k]) s = k;
        sgl = 0; odd = 0; msbf = 0; value = 0;
        if (s >= 0) begin
            sgl   = bits[s+1];
            odd   = bits[s+2];
            msbf  = bits[s+3];
            value = conv_value(sgl, odd, d0, d1);
        end
        dout_q.push_back(0);
        for (int b = DATA_W - 1; b >= 0; b--) dout_q.push_back((value >> b) & 1);
        if (!msbf) for (int b = 1; b < DATA_W; b++) dout_q.push_back((value >> b) & 1);
        need = msbf ? DATA_W + 2 : 2 * DATA_W + 1;

        exp_samp = (s >= 0 && s + 2 < n_clk) ? 1 : 0;
        falls    = (s >= 0 && s + 3 < n_clk) ? (n_clk - s - 4 + (cpol ? 0 : 1)) : 0;
        exp_err  = 0;
        exp_end  = 0;
        if (s >= 0 && rst_at < 0) begin
            if (s + 3 >= n_clk) exp_err = 1;
            else exp_err = (falls < need) ? 1 : 0;
            if (s + 3 < n_clk && falls >= 1 && falls < need) exp_end = 2 | dout_q[falls-1];
        end

        i_data0     = DATA_W'(d0);
        i_data1     = DATA_W'(d1);
        chg_pending = chg;
        chg_val     = DATA_W'(chg_to);
        n_samp      = 0;
        n_ferr      = 0;
        p_clk       = cpol;
        wait_clk(4);
        p_cs = 1'b0;
        wait_clk(HALF);

        for (int k = 0; k < n_clk; k++) begin
            p_clk = 1'b0;
            p_in  = bits[k];
            wait_clk(HALF);
            j     = k - (s + 4);
            exp_v = 0;
            if (s >= 0 && j >= 0 && j < dout_q.size() && (rst_at < 0 || k <= rst_at))
                exp_v = 2 | dout_q[j];
            check_eq($sformatf("%s rise%0d {en,dout}", name, k), int'({o_out_en, p_out}), exp_v);
            p_clk = 1'b1;
            if (k == rst_at) begin
                i_rst = 1'b1;
                wait_clk(1);
                i_rst = 1'b0;
                check_eq({name, " reset outputs"},
                         int'({p_out, o_out_en, o_sample, o_channel, o_frame_error}), 0);
                wait_clk(HALF - 1);
            end else begin
                wait_clk(HALF);
            end
        end
        if (!cpol) begin
            p_clk = 1'b0;
            wait_clk(HALF);
        end
        check_eq({name, " end of clocks {en,dout}"}, int'({o_out_en, p_out}), exp_end);

        p_cs = 1'b1;
        wait_clk(SYNC_STAGES + 2);
        check_eq({name, " after cs rise {en,dout}"}, int'({o_out_en, p_out}), 0);
        wait_clk(6);
        check_eq({name, " frame_error pulses"}, n_ferr, exp_err);
        check_eq({name, " sample pulses"}, n_samp, exp_samp);
        if (rst_at >= 0) begin
            check_eq({name, " channel after reset"}, int'(o_channel), 0);
        end else if (exp_samp == 1) begin
            check_eq({name, " channel at sample"}, int'(last_chan), int'(odd));
            check_eq({name, " channel held"}, int'(o_channel), int'(odd));
        end
        $display("frame %s: din_start=%0d clocks=%0d cpol=%0d value=%0d", name, s, n_clk, cpol, value);
    endtask

    initial begin
        logic [63:0] rb;
        int lead, n, extra;
        bit msbf_r;

        i_rst   = 1'b1;
        p_cs    = 1'b1;
        p_clk   = 1'b0;
        p_in    = 1'b0;
        i_data0 = '0;
        i_data1 = '0;
        chg_pending = 1'b0;
        chg_val     = '0;
        n_samp = 0;
        n_ferr = 0;
        last_chan = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("reset state", int'({p_out, o_out_en, o_sample, o_channel, o_frame_error}), 0);
        i_rst = 1'b0;
        wait_clk(6);

        run_frame("se_ch0_msbf",   64'b1011,    15, 1'b0, 'h2A5, 'h155, 1'b0, 0, -1);
        run_frame("se_ch1_lsbf",   64'b0111,    24, 1'b0, 'h0F0, 'h001, 1'b0, 0, -1);
        run_frame("pdiff_pos",     64'b1001000, 18, 1'b0, 300, 100, 1'b0, 0, -1);
        run_frame("pdiff_sat",     64'b1001000, 18, 1'b0, 100, 300, 1'b0, 0, -1);
        run_frame("abort",         64'b1011,     4, 1'b0, 'h2A5, 'h000, 1'b0, 0, -1);
        run_frame("after_abort",   64'b1011,    15, 1'b0, 'h2A5, 'h000, 1'b0, 0, -1);
        run_frame("data_stable",   64'b1011,    15, 1'b0, 'h3FF, 'h000, 1'b1, 0, -1);
        run_frame("reset_mid_msb", 64'b1111,    15, 1'b0, 'h000, 'h2A5, 1'b0, 0, 8);
        run_frame("after_reset",   64'b0111,    24, 1'b1, 'h123, 'h2C7, 1'b0, 0, -1);

        for (int t = 0; t < 40; t++) begin
            rb   = {$urandom, $urandom};
            lead = $urandom_range(0, 3);
            for (int k = 0; k < lead; k++) rb[k] = 1'b0;
            rb[lead] = 1'b1;
            msbf_r   = rb[lead+3];
            extra    = $urandom_range(0, 3);
            n        = lead + 4 + (msbf_r ? DATA_W + 1 : 2 * DATA_W) + extra;
            if ($urandom_range(0, 3) == 0) n = $urandom_range(1, n);
            run_frame($sformatf("rand%0d", t), rb, n, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 1023), $urandom_range(0, 1023),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 1023), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable SPI responder that emulates a two-channel 10-bit SAR ADC (MCP3002-style) on the scope's 4-wire ADC header: CLK, CS and IN are inputs; OUT is an output.
- Used as a loopback target for the ADC initiator: a second board or another PMOD port serves stored or generated samples. This lets the full scope path (shift registers, VGA traces, 7-segment voltage display) be exercised without analog hardware.
- Runs entirely on the fast system clock. The SPI pins are oversampled; SCLK is never used as a clock.

Parameters:
- DATA_W, 10, sample width and number of data bits shifted out.
- SYNC_STAGES, 2, flip-flop synchronizer depth on p_clk, p_cs and p_in (minimum 2).

Ports:
- i_clk  in  1  system clock; must be at least 8x the SCLK frequency.
- i_rst  in  1  synchronous reset, active-high.
- p_clk  in  1  SPI SCLK from the initiator; idle low.
- p_cs  in  1  SPI chip select, active-low.
- p_in  in  1  SPI DIN (initiator to responder).
- p_out  out  1  SPI DOUT (responder to initiator).
- o_out_en  out  1  1 = p_out is driven; 0 = the top level tri-states the pin.
- i_data0  in  DATA_W  channel 0 value.
- i_data1  in  DATA_W  channel 1 value.
- o_sample  out  1  one-cycle pulse when the conversion value is latched.
- o_channel  out  1  channel (ODD bit) captured at the last o_sample.
- o_frame_error  out  1  one-cycle pulse when CS rises mid-frame.

Behaviour:
- **Reset.** Reset values: p_out=0, o_out_en=0, o_sample=0, o_channel=0, o_frame_error=0, state=IDLE. Synchronizer registers reset to p_cs=1 and p_clk=0.
- **Edge detection.** Edges are taken from the synchronized signals: rise = sclk_s & ~sclk_q; fall = ~sclk_s & sclk_q.
  - DIN is sampled on rise.
  - DOUT changes on fall.
  - p_out and o_out_en settle at most SYNC_STAGES+2 i_clk cycles after the pin edge.
- **State machine.** States: IDLE, START, CFG, NULL, MSB, LSB, DONE.
  - IDLE: enter START when cs_s falls. o_out_en=0.
  - START: on each rise, if din=1 go to CFG with bit count 0. Leading zeros are ignored, in any number.
  - CFG: capture 3 bits on successive rises: SGL, ODD, MSBF.
    - On the rise that captures ODD: latch the conversion value, pulse o_sample, update o_channel.
    - On the rise that captures MSBF: go to NULL.
  - NULL: on the next fall, drive p_out=0 (the null bit), set o_out_en=1, go to MSB with index DATA_W-1.
  - MSB: on each fall, drive value[index] and decrement index.
    - After bit 0 has been driven, the next fall exits MSB.
    - If MSBF=1: go to DONE.
    - If MSBF=0: go to LSB and drive value[1] on that fall.
  - LSB: on each fall, drive value[1], value[2], ..., value[DATA_W-1]. Bit 0 is not repeated. On the fall after value[DATA_W-1], go to DONE.
  - DONE: o_out_en=0, p_out=0. Extra clocks are ignored until CS rises.
- **Conversion value.**
  - SGL=1: value = ODD ? i_data1 : i_data0.
  - SGL=0 (pseudo-differential): ODD=0 gives data0-data1; ODD=1 gives data1-data0. Compute at DATA_W+1 bits; a negative result saturates to 0.
  - The value is frozen for the rest of the frame. Changes on i_data* after the latch must not affect shifted bits.
- **CS rise (cs_s 0 to 1) in any state.** Go to IDLE the same cycle, o_out_en=0, p_out=0.
  - o_frame_error pulses if the state was CFG, NULL, MSB or LSB.
  - No pulse from START or DONE.
- **Simultaneous events.** CS rise has priority over any clock edge detected in the same cycle. SCLK edges while cs_s=1 are ignored.
- **Reset mid-frame.** Return to reset values immediately. A frame that continues afterwards is not serviced until CS goes high and then low again.
- **SPI mode.** Modes 0,0 and 1,1 are both supported, because only edges after CS low are used.

Test Plan:
- **Single-ended ch0, MSBF=1.** i_data0=0x2A5. DIN 1,1,0,1 then 11 more SCLKs. Sampled DOUT after the config bits must be 0,1,0,1,0,1,0,0,1,0,1. Check o_sample=1 once, o_channel=0, o_out_en low after bit 0.
- **Single-ended ch1, MSBF=0.** i_data1=0x001. DIN 1,1,1,0 then 20 SCLKs. DOUT must be null 0, then 0000000001, then 000000000 (LSB-first bits 1..9). o_channel=1.
- **Leading zeros, then pseudo-diff.** DIN 0,0,0,1,0,0,1.
  - data0=300, data1=100: DOUT=0 then 0011001000 (200).
  - Swap the values: DOUT=0 then all zeros (saturation).
- **Abort.** CS raised after 4 data bits: o_frame_error pulses once, o_out_en=0 within SYNC_STAGES+2 cycles. The next full frame returns correct data.
- **Data stability.** Change i_data0 from 0x3FF to 0x000 right after o_sample: the frame still shifts 1111111111.
- **Reset mid-MSB.** Assert i_rst for 1 cycle: all outputs go to reset values. Remaining SCLKs give o_out_en=0. A new CS frame works normally.
